fetch_ctrl_decode: RTL and testbench

Program sequencer and instruction decoder for the 8-bit single-cycle core. Sits directly upstream of the instruction-fetch stage. It receives the 9-bit instruction read asynchronously from instruction ROM at the current `PC`, and drives the fetch stage's `start`, `jump`, `Branch`, `offset` and `halt` inputs. It also owns run/halt sequencing, a retired-instruction counter and a watchdog that force-halts runaway programs.

---
 rtl/fetch_ctrl_decode.sv | 117 +++++++++++
 tb/tb_fetch_ctrl_decode.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_decode.sv
// Program sequencer and instruction decoder feeding the fetch stage.
// Owns run/halt sequencing, the retired-instruction counter and the runaway watchdog.
module fetch_ctrl_decode #(
   parameter int CNT_W     = 16,
   parameter int MAX_INSTR = 1000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             go,
   input  logic [7:0]       PC,
   input  logic [8:0]       instr,
   output logic             start,
   output logic             jump,
   output logic             Branch,
   output logic [7:0]       offset,
   output logic             halt,
   output logic [2:0]       alu_op,
   output logic [2:0]       reg_a,
   output logic [2:0]       reg_b,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] inst_count
);

   if (MAX_INSTR < 1 || MAX_INSTR > (2 ** CNT_W) - 1) begin : g_param_check
      $error("fetch_ctrl_decode: MAX_INSTR must be in 1 .. 2**CNT_W-1");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } state_t;

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_INSTR - 1);

   state_t           state_q, state_d;
   logic             go_q;
   logic [CNT_W-1:0] inst_count_q, inst_count_d;
   logic             timeout_q, timeout_d;
   logic             start_q, start_d;
   logic             done_q, done_d;

   logic go_rise;
   logic running;
   logic is_halt_op;
   logic wd_hit;

   // The PC is only observed by this block; the fetch stage owns it.
   logic unused_pc;
   assign unused_pc = ^PC;

   always_comb begin
      go_rise    = go & ~go_q;
      running    = (state_q == RUN);
      is_halt_op = (instr == 9'h000);
      wd_hit     = (inst_count_q == WD_LAST);

      halt   = running & (is_halt_op | wd_hit);
      jump   = running & ~halt & (instr[8:6] == 3'b110);
      Branch = running & ~halt & (instr[8:6] == 3'b111);
      offset = (jump | Branch) ? {{2{instr[5]}}, instr[5:0]} : 8'h00;
   end

   assign alu_op     = instr[8:6];
   assign reg_a      = instr[5:3];
   assign reg_b      = instr[2:0];
   assign start      = start_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign inst_count = inst_count_q;

   // A timeout is recorded only when the watchdog, not a HALT opcode, ended the run.
   always_comb begin
      state_d      = state_q;
      inst_count_d = inst_count_q;
      timeout_d    = timeout_q;
      case (state_q)
         IDLE, HALTED: begin
            if (go_rise) begin
               state_d      = RUN;
               inst_count_d = '0;
               timeout_d    = 1'b0;
            end
         end
         RUN: begin
            inst_count_d = inst_count_q + 1'b1;
            if (halt) begin
               state_d   = HALTED;
               timeout_d = wd_hit & ~is_halt_op;
            end
         end
         default: state_d = IDLE;
      endcase
      start_d = (state_d != RUN);
      done_d  = (state_d == HALTED);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         go_q         <= 1'b0;
         inst_count_q <= '0;
         timeout_q    <= 1'b0;
         start_q      <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         go_q         <= go;
         inst_count_q <= inst_count_d;
         timeout_q    <= timeout_d;
         start_q      <= start_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl_decode.sv
// Bench for fetch_ctrl_decode: a run-level model plus a simple fetch-stage/ROM environment,
// directed scenarios with literal expectations, then randomized programs, go activity and resets.
module tb_fetch_ctrl_decode;

   localparam int CNT_W     = 16;
   localparam int MAX_INSTR = 5;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             go;
   logic [7:0]       PC;
   logic [8:0]       instr;
   logic             start, jump, Branch, halt, done, timeout;
   logic [7:0]       offset;
   logic [2:0]       alu_op, reg_a, reg_b;
   logic [CNT_W-1:0] inst_count;

   logic [8:0] rom [256];
   bit         r15;
   logic [7:0] pc_next;
   int         tests = 0;
   int         fails = 0;

   // Run-level model: is a run in progress, how many instructions it has retired, and how the last one ended.
   bit m_run, m_done, m_timeout, m_go_prev;
   int m_count;

   fetch_ctrl_decode #(.CNT_W(CNT_W), .MAX_INSTR(MAX_INSTR)) dut (
      .CLK(CLK), .RST_N(RST_N), .go(go), .PC(PC), .instr(instr),
      .start(start), .jump(jump), .Branch(Branch), .offset(offset), .halt(halt),
      .alu_op(alu_op), .reg_a(reg_a), .reg_b(reg_b),
      .done(done), .timeout(timeout), .inst_count(inst_count)
   );

   always #5 CLK = ~CLK;

   assign instr = rom[PC];

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit go_val);
      #1 go = go_val;
   endtask

   function automatic bit model_halt();
      return m_run && (instr == 9'h000 || m_count == MAX_INSTR - 1);
   endfunction

   function automatic logic [8:0] rand_instr();
      int k;
      k = $urandom_range(0, 15);
      if (k == 0) return 9'h000;
      if (k < 4)  return {3'b110, 6'($urandom)};
      if (k < 7)  return {3'b111, 6'($urandom)};
      return 9'($urandom);
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_run     <= 1'b0;
         m_done    <= 1'b0;
         m_timeout <= 1'b0;
         m_count   <= 0;
         m_go_prev <= 1'b0;
      end else begin
         m_go_prev <= go;
         if (m_run) begin
            m_count <= m_count + 1;
            if (model_halt()) begin
               m_run     <= 1'b0;
               m_done    <= 1'b1;
               m_timeout <= (instr != 9'h000);
            end
         end else if (go && !m_go_prev) begin
            m_run     <= 1'b1;
            m_done    <= 1'b0;
            m_timeout <= 1'b0;
            m_count   <= 0;
         end
      end
   end

   // Every cycle: compare all outputs against the model, then advance the fetch-stage PC.
   always @(negedge CLK) begin : cmp
      bit         e_halt, e_jmp, e_br;
      int         sv;
      logic [7:0] e_off;
      e_halt = model_halt();
      e_jmp  = m_run && !e_halt && instr[8:6] == 3'b110;
      e_br   = m_run && !e_halt && instr[8:6] == 3'b111;
      sv     = int'(instr[5:0]);
      if (sv >= 32) sv = sv - 64;
      e_off  = (e_jmp || e_br) ? 8'(sv) : 8'h00;
      checkOutput("start",      start,      !m_run);
      checkOutput("done",       done,       m_done);
      checkOutput("halt",       halt,       e_halt);
      checkOutput("jump",       jump,       e_jmp);
      checkOutput("Branch",     Branch,     e_br);
      checkOutput("offset",     offset,     e_off);
      checkOutput("alu_op",     alu_op,     instr / 64);
      checkOutput("reg_a",      reg_a,      (instr / 8) % 8);
      checkOutput("reg_b",      reg_b,      instr % 8);
      checkOutput("timeout",    timeout,    m_timeout);
      checkOutput("inst_count", inst_count, m_count);
      if (!m_run || e_halt)          pc_next = 8'h00;
      else if (e_jmp || (e_br && r15)) pc_next = PC + e_off;
      else                           pc_next = PC + 8'd1;
   end

   always @(posedge CLK) begin
      #1 PC = pc_next;
   end

   initial begin
      RST_N   = 1'b0;
      go      = 1'b0;
      PC      = 8'h00;
      pc_next = 8'h00;
      r15     = 1'b0;
      for (int a = 0; a < 256; a++) rom[a] = 9'h041;
      rom[0] = 9'h000;

      // Reset, with a HALT opcode sitting at PC 0 while idle
      repeat (3) @(negedge CLK);
      checkOutput("rst_start",      start,      1);
      checkOutput("rst_done",       done,       0);
      checkOutput("rst_count",      inst_count, 0);
      checkOutput("rst_timeout",    timeout,    0);
      checkOutput("idle_halt",      halt,       0);
      checkOutput("idle_jump",      jump,       0);
      checkOutput("idle_offset",    offset,     0);
      #1 RST_N = 1'b1;

      // ALU, ALU, HALT
      rom[0] = 9'h041; rom[1] = 9'h0AB; rom[2] = 9'h000;
      @(negedge CLK); applyStimulus(1);
      @(negedge CLK);
      checkOutput("t1_c1_start",  start,  0);
      checkOutput("t1_c1_halt",   halt,   0);
      checkOutput("t1_c1_alu_op", alu_op, 3'b001);
      checkOutput("t1_c1_reg_b",  reg_b,  3'b001);
      @(negedge CLK);
      checkOutput("t1_c2_halt",   halt,       0);
      checkOutput("t1_c2_count",  inst_count, 1);
      @(negedge CLK);
      checkOutput("t1_c3_halt",   halt,       1);
      @(negedge CLK);
      checkOutput("t1_done",      done,       1);
      checkOutput("t1_count",     inst_count, 3);
      checkOutput("t1_timeout",   timeout,    0);
      checkOutput("t1_start",     start,      1);
      applyStimulus(0);

      // JMP -2 wraps to 254, BR +31 wraps to 29, HALT
      rom[0] = 9'b110_111110; rom[254] = 9'b111_011111; rom[29] = 9'h000;
      r15 = 1'b1;
      @(negedge CLK); applyStimulus(1);
      @(negedge CLK);
      checkOutput("t2_jump",    jump,   1);
      checkOutput("t2_joff",    offset, 8'hFE);
      checkOutput("t2_jbr",     Branch, 0);
      @(negedge CLK);
      checkOutput("t2_branch",  Branch, 1);
      checkOutput("t2_boff",    offset, 8'h1F);
      @(negedge CLK);
      checkOutput("t2_pc",      PC,     29);
      checkOutput("t2_halt",    halt,   1);
      @(negedge CLK);
      checkOutput("t2_count",   inst_count, 3);
      applyStimulus(0);

      // Tight loop with no HALT: the watchdog ends it after MAX_INSTR instructions
      rom[0] = 9'h041; rom[1] = 9'b110_111111;
      @(negedge CLK); applyStimulus(1);
      repeat (4) @(negedge CLK);
      checkOutput("t3_c4_halt", halt, 0);
      @(negedge CLK);
      checkOutput("t3_c5_halt", halt, 1);
      @(negedge CLK);
      checkOutput("t3_done",    done,       1);
      checkOutput("t3_timeout", timeout,    1);
      checkOutput("t3_count",   inst_count, 5);

      // go held high across HALTED must not relaunch
      repeat (3) @(negedge CLK);
      checkOutput("t4_hold_done",  done,       1);
      checkOutput("t4_hold_count", inst_count, 5);
      applyStimulus(0);
      @(negedge CLK); applyStimulus(1);
      @(negedge CLK);
      checkOutput("t4_relaunch_start", start,      0);
      checkOutput("t4_relaunch_count", inst_count, 0);
      checkOutput("t4_relaunch_tmo",   timeout,    0);
      @(negedge CLK);
      checkOutput("t4_count1", inst_count, 1);

      // Reset pulsed in the second RUN cycle
      #2 RST_N = 1'b0;
      #1;
      checkOutput("t5_start", start,      1);
      checkOutput("t5_done",  done,       0);
      checkOutput("t5_count", inst_count, 0);
      checkOutput("t5_halt",  halt,       0);
      go = 1'b0;
      @(negedge CLK); #1 RST_N = 1'b1;
      @(negedge CLK);
      checkOutput("t5_idle_start", start, 1);

      // Randomized programs, go activity, branch flag and occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(posedge CLK); #2;
         if (c % 150 == 0) for (int a = 0; a < 256; a++) rom[a] = rand_instr();
         r15 = 1'($urandom);
         if ($urandom_range(0, 3) == 0) go = ~go;
         if ($urandom_range(0, 299) == 0) begin
            RST_N = 1'b0;
            #2 RST_N = 1'b1;
         end
      end

      @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
